// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter merging two register write requesters onto one write port
module reg_write_arbiter #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_data,
    output logic              req1_ready,
    input  logic              req1_block,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_src,
    output logic              err_pulse,
    output logic [7:0]        drop_cnt
);
    typedef enum logic {IDLE, COMMIT} state_t;
    // one extra bit so NUM_REGS == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
    state_t state, state_nxt;
    logic last_grant, e0, e1, acc, sel, ok;
    logic [ADDR_W-1:0] addr;
    logic [7:0] data;
    always_comb begin
        e0 = req0_valid;
        e1 = req1_valid & ~req1_block;
        req0_ready = ~rst & (state == IDLE) & e0 & (~e1 | last_grant);
        req1_ready = ~rst & (state == IDLE) & e1 & (~e0 | ~last_grant);
        acc = req0_ready | req1_ready;
        sel = req1_ready;
        addr = sel ? req1_addr : req0_addr;
        data = sel ? req1_data : req0_data;
        ok = {1'b0, addr} < LIMIT;
        state_nxt = (acc & ok) ? COMMIT : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_src     <= 1'b0;
            err_pulse  <= 1'b0;
            drop_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            wr_en     <= acc & ok;
            err_pulse <= acc & ~ok;
            if (acc & ~ok & (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
            if (acc) begin
                wr_addr    <= addr;
                wr_data    <= data;
                wr_src     <= sel;
                last_grant <= sel;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;
    logic       clk = 0;
    logic       rst;
    logic       req0_valid, req1_valid, req1_block;
    logic [6:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       wr_en, wr_src, err_pulse;
    logic [6:0] wr_addr;
    logic [7:0] wr_data, drop_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int seen_wr, seen_rdy;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .req1_block(req1_block),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src),
        .err_pulse(err_pulse), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; req0_valid = 1; req1_valid = 0; req1_block = 0;
        req0_addr = 7'h02; req0_data = 8'hA5; req1_addr = 0; req1_data = 0;
        tick(); tick();
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_wr_src", 32'(wr_src), 0);
        chk("rst_err", 32'(err_pulse), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // single write, granted in the first cycle out of reset
        rst = 0; #1;
        chk("single_ready0", 32'(req0_ready), 1);
        chk("single_ready1", 32'(req1_ready), 0);
        tick();
        chk("single_wr_en", 32'(wr_en), 1);
        chk("single_wr_addr", 32'(wr_addr), 'h02);
        chk("single_wr_data", 32'(wr_data), 'hA5);
        chk("single_wr_src", 32'(wr_src), 0);
        chk("commit_ready0_low", 32'(req0_ready), 0);
        req0_valid = 0; #1;
        tick();
        chk("single_wr_en_drop", 32'(wr_en), 0);

        // tie after reset: req0 first, then alternate, one write per 2 cycles
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_addr = 7'h00; req0_data = 8'h11;
        req1_valid = 1; req1_addr = 7'h01; req1_data = 8'h22;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("tie_ready0", 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
            chk("tie_ready1", 32'(req1_ready), (k % 2 == 0) ? 0 : 1);
            tick();
            chk("tie_wr_en", 32'(wr_en), 1);
            chk("tie_wr_data", 32'(wr_data), (k % 2 == 0) ? 'h11 : 'h22);
            chk("tie_wr_src", 32'(wr_src), (k % 2 == 0) ? 0 : 1);
            chk("tie_commit_ready", 32'(req0_ready | req1_ready), 0);
            tick();
            chk("tie_gap_wr_en", 32'(wr_en), 0);
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // invalid address from requester 1
        req1_valid = 1; req1_addr = 7'h05; req1_data = 8'hFF; #1;
        chk("inv_ready1", 32'(req1_ready), 1);
        tick();
        chk("inv_wr_en", 32'(wr_en), 0);
        chk("inv_err", 32'(err_pulse), 1);
        chk("inv_drop1", 32'(drop_cnt), 1);
        chk("inv_wr_addr", 32'(wr_addr), 'h05);
        chk("inv_wr_data", 32'(wr_data), 'hFF);
        chk("inv_wr_src", 32'(wr_src), 1);
        req1_valid = 0;
        tick();
        chk("inv_err_one_cycle", 32'(err_pulse), 0);
        chk("inv_drop_hold", 32'(drop_cnt), 1);

        // back-to-back invalid requests until saturation
        req1_valid = 1; seen_wr = 0;
        for (int i = 0; i < 10; i++) begin tick(); seen_wr |= int'(wr_en); end
        chk("sat_drop11", 32'(drop_cnt), 11);
        chk("sat_err_stream", 32'(err_pulse), 1);
        for (int i = 0; i < 250; i++) begin tick(); seen_wr |= int'(wr_en); end
        chk("sat_drop255", 32'(drop_cnt), 255);
        chk("sat_no_wr", 32'(seen_wr), 0);
        req1_valid = 0;
        tick();

        // blocked requester 1
        req1_block = 1; req1_valid = 1; req1_addr = 7'h03; req1_data = 8'h5C;
        seen_wr = 0; seen_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            #1; seen_rdy |= int'(req1_ready);
            tick(); seen_wr |= int'(wr_en);
        end
        chk("blk_no_ready", 32'(seen_rdy), 0);
        chk("blk_no_wr", 32'(seen_wr), 0);
        req1_block = 0; #1;
        chk("blk_release_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        chk("blk_wr_en", 32'(wr_en), 1);
        chk("blk_wr_addr", 32'(wr_addr), 'h03);
        chk("blk_wr_data", 32'(wr_data), 'h5C);
        chk("blk_wr_src", 32'(wr_src), 1);
        tick();

        // reset mid-commit, then tie must go to requester 0
        req0_valid = 1; req0_addr = 7'h04; req0_data = 8'h77; #1;
        tick();
        chk("mid_wr_en", 32'(wr_en), 1);
        rst = 1; req0_valid = 0;
        tick();
        rst = 0;
        chk("mid_abort_wr_en", 32'(wr_en), 0);
        chk("mid_drop_clr", 32'(drop_cnt), 0);
        req0_valid = 1; req0_addr = 7'h00; req0_data = 8'h11;
        req1_valid = 1; req1_addr = 7'h01; req1_data = 8'h22; #1;
        chk("mid_tie_ready0", 32'(req0_ready), 1);
        chk("mid_tie_ready1", 32'(req1_ready), 0);
        tick();
        chk("mid_tie_src", 32'(wr_src), 0);
        chk("mid_tie_data", 32'(wr_data), 'h11);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
